// File: rtl/mem_dump_reader.sv
// Streams a block of words from data-memory port B through a small credit-managed
// output FIFO onto a valid/ready stream, strictly in address order.
module mem_dump_reader #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] read_data_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int INF_W = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q, len_q, issued, issued_inc;
  logic              issue_q;
  logic [RD_LAT-1:0] tag;
  logic [INF_W-1:0]  inflight;
  logic              credit, issue, load, done_set, flush;

  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              push, pop;

  assign issued_inc = issued + ADDR_W'(1);
  assign busy       = (state != IDLE);
  assign push       = tag[RD_LAT-1];
  assign pop        = out_valid && out_ready;

  // A read is in flight from the cycle its address sits on address_b (issue_q)
  // until its tag leaves the end of the RD_LAT-deep shift register.
  always_comb begin
    inflight = INF_W'(issue_q);
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + INF_W'(tag[i]);
    end
  end

  assign credit = (32'(count) + 32'(inflight)) < 32'(DEPTH);

  // NOTE: every output of this block gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    load      = 1'b0;
    done_set  = 1'b0;
    flush     = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      flush     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              load      = 1'b1;
              state_nxt = RUN;
            end else begin
              done_set = 1'b1;
            end
          end
        end
        RUN: begin
          if (credit) begin
            issue = 1'b1;
            if (issued_inc == len_q) state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0 && count == '0) begin
            state_nxt = IDLE;
            done_set  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      issued    <= '0;
      address_b <= '0;
      issue_q   <= 1'b0;
      tag       <= '0;
      done      <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= done_set;
      issue_q <= issue;
      if (load) begin
        base_q <= base_addr;
        len_q  <= length;
        issued <= '0;
      end else if (issue) begin
        issued <= issued_inc;
      end
      if (issue) address_b <= base_q + issued;
      if (flush) begin
        tag <= '0;
      end else begin
        tag[0] <= issue_q;
        for (int i = 1; i < RD_LAT; i++) begin
          tag[i] <= tag[i-1];
        end
      end
    end
  end

  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);

  // NOTE: the storage array has no reset; only pointers, count and the
  // registered head carry state that matters after reset.
  always_ff @(posedge clk) begin
    if (push && !flush) fifo_mem[wr_ptr] <= read_data_b;
  end

  // out_data mirrors the FIFO head in a register so the stream output is flop-driven.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr_inc;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      if (pop) begin
        if (count > CNT_W'(1)) out_data <= fifo_mem[rd_ptr_inc];
        else if (push)         out_data <= read_data_b;
      end else if (count == '0 && push) begin
        out_data <= read_data_b;
      end
    end
  end

  // Credit accounting keeps one free slot for every read still in flight.
  always_ff @(posedge clk) begin
    if (rst && push && !flush) begin
      overflow_chk: assert (count < CNT_W'(DEPTH))
        else $error("mem_dump_reader: capture into full FIFO");
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: port-B memory model, expected words and
// addresses queued at stimulus time, independent monitor popping and comparing.
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        rst, start, abort, busy, done, out_valid, out_ready;
  logic [17:0] base_addr, length, address_b;
  logic [23:0] read_data_b, out_data;

  mem_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .address_b  (address_b),
    .read_data_b(read_data_b),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [23:0] mem_img [logic [17:0]];
  logic [23:0] exp_q [$];
  logic [17:0] addr_q [$];
  logic [17:0] prev_addr = '0;
  int          done_cnt = 0, done_base = 0;
  int          xfer_issued = 0, xfer_taken = 0, max_out = 0;

  function automatic logic [23:0] mem_rd(input logic [17:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return 24'hEEEEEE;
  endfunction

  // Port B with one cycle of read latency.
  always @(posedge clk) read_data_b <= mem_rd(address_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      xfer_taken++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
      end else begin
        check("stream_word", out_data, exp_q.pop_front());
      end
    end
    if (rst && address_b != prev_addr) begin
      xfer_issued++;
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_addr: got 0x%0h, expected no read", address_b);
      end else begin
        check("read_addr", address_b, addr_q.pop_front());
      end
    end
    prev_addr = address_b;
    if (xfer_issued - xfer_taken > max_out) max_out = xfer_issued - xfer_taken;
    if (rst && done) begin
      done_cnt++;
      check("busy_low_at_done", busy, 0);
    end
  end

  task automatic new_xfer();
    exp_q.delete();
    addr_q.delete();
    xfer_issued = 0;
    xfer_taken  = 0;
    max_out     = 0;
    done_base   = done_cnt;
  endtask

  // Called at posedge+1; start is sampled by the next edge (edge 0).
  task automatic start_xfer(input logic [17:0] b, input logic [17:0] n);
    base_addr = b;
    length    = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_xfer(input string name, input bit toggle);
    int i;
    i = 0;
    while (!done && i < 200) begin
      if (toggle) out_ready = (i % 4 == 0) || (i % 4 == 3);
      @(posedge clk); #1;
      i++;
    end
    check({name, "_done_seen"}, done, 1);
    check({name, "_valid_at_done"}, out_valid, 0);
    @(posedge clk); #1;
    check({name, "_done_single"}, done, 0);
    check({name, "_done_count"}, done_cnt - done_base, 1);
    check({name, "_words_left"}, exp_q.size(), 0);
    check({name, "_addrs_left"}, addr_q.size(), 0);
    out_ready = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; length = '0; out_ready = 1'b0;
    mem_img[18'h00010] = 24'hA00001; mem_img[18'h00011] = 24'hA00002;
    mem_img[18'h00012] = 24'hA00003; mem_img[18'h00013] = 24'hA00004;
    mem_img[18'h3FFFE] = 24'hC0FFFE; mem_img[18'h3FFFF] = 24'hC0FFFF;
    mem_img[18'h00000] = 24'hC00000; mem_img[18'h00001] = 24'hC00001;
    for (int i = 0; i < 8; i++) mem_img[18'h00020 + 18'(i)] = 24'hB00020 + 24'(i);
    mem_img[18'h00100] = 24'h5A5A5A;

    repeat (3) @(posedge clk); #1;
    check("rst_address_b", address_b, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic 4-word transfer, consumer always ready.
    new_xfer();
    out_ready = 1'b1;
    addr_q = '{18'h10, 18'h11, 18'h12, 18'h13};
    exp_q  = '{24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004};
    start_xfer(18'h00010, 18'd4);
    check("busy_after_start", busy, 1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("first_valid_edge", n, 3);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("sustained_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    check("valid_after_last", out_valid, 0);
    finish_xfer("basic", 1'b0);

    // Same transfer under a 1,0,0,1 ready pattern.
    new_xfer();
    addr_q = '{18'h10, 18'h11, 18'h12, 18'h13};
    exp_q  = '{24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004};
    start_xfer(18'h00010, 18'd4);
    finish_xfer("bp", 1'b1);
    check("bp_outstanding_le_depth", max_out <= 4, 1);

    // Address wrap past the top of port B.
    new_xfer();
    addr_q = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    exp_q  = '{24'hC0FFFE, 24'hC0FFFF, 24'hC00000, 24'hC00001};
    start_xfer(18'h3FFFE, 18'd4);
    finish_xfer("wrap", 1'b0);

    // Zero-length command.
    new_xfer();
    start_xfer(18'h00040, 18'd0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_valid", out_valid, 0);
    @(posedge clk); #1;
    check("len0_done_single", done, 0);
    check("len0_done_count", done_cnt - done_base, 1);

    // Abort with two of eight words consumed and the consumer stalled.
    new_xfer();
    addr_q = '{18'h20, 18'h21, 18'h22, 18'h23, 18'h24, 18'h25, 18'h26, 18'h27};
    exp_q  = '{24'hB00020, 24'hB00021, 24'hB00022, 24'hB00023,
               24'hB00024, 24'hB00025, 24'hB00026, 24'hB00027};
    start_xfer(18'h00020, 18'd8);
    n = 0;
    while (xfer_taken < 2 && n < 50) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    check("abort_two_taken", xfer_taken, 2);
    repeat (3) @(posedge clk); #1;
    check("abort_issued_at_stall", xfer_issued, 6);
    check("abort_valid_before", out_valid, 1);
    abort = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1;
    check("abort_no_done", done_cnt - done_base, 0);
    new_xfer();
    out_ready = 1'b1;
    addr_q = '{18'h100};
    exp_q  = '{24'h5A5A5A};
    start_xfer(18'h00100, 18'd1);
    finish_xfer("post_abort", 1'b0);

    // Asynchronous reset in the middle of a transfer.
    new_xfer();
    out_ready = 1'b0;
    addr_q = '{18'h10, 18'h11, 18'h12, 18'h13};
    start_xfer(18'h00010, 18'd4);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_address_b", address_b, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle", busy, 0);
    new_xfer();
    out_ready = 1'b1;
    addr_q = '{18'h10, 18'h11, 18'h12, 18'h13};
    exp_q  = '{24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004};
    start_xfer(18'h00010, 18'd4);
    finish_xfer("post_rst", 1'b0);

    repeat (3) @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
Streams a contiguous block of 24-bit words out of data-memory port B, which the processor's memory stage currently leaves idle, to a downstream consumer such as a UART or display driver.
- Sits directly downstream of the data memory's second port and owns address_b.
- Accepts a start command with base address and word count, issues pipelined synchronous reads, and buffers the returned words.
- Delivers words in address order on a valid/ready stream with full backpressure.

Parameters:
ADDR_W, 18, port-B word address width
DATA_W, 24, memory word width
RD_LAT, 1, port-B read latency in cycles (1 or 2), address to read_data_b
DEPTH, 4, output FIFO depth in words (power of 2, >= RD_LAT+1)

Ports:
clk  in  1  system clock; port B is clocked by this same clock in this integration
rst  in  1  asynchronous, active-low reset
start  in  1  command strobe, sampled only in IDLE
abort  in  1  synchronous cancel of the current transfer
base_addr  in  ADDR_W  first word address, captured on accepted start
length  in  ADDR_W  word count, captured on accepted start
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when a transfer completes
address_b  out  ADDR_W  registered read address to memory port B
read_data_b  in  DATA_W  port-B read data, valid RD_LAT cycles after address
out_data  out  DATA_W  stream data (FIFO head)
out_valid  out  1  stream valid
out_ready  in  1  consumer ready; a transfer occurs when out_valid && out_ready

Behaviour:
- Reset (rst low, async): state IDLE; address_b=0, out_data=0, out_valid=0, busy=0, done=0; FIFO, counters and in-flight pipe cleared.
- FSM IDLE:
  - start && length!=0: capture base/length, go to RUN next edge.
  - start && length==0: done pulses the next cycle, stay IDLE.
  - start while busy: ignored.
- FSM RUN: one read issued per cycle when credit is available.
  - Credit condition: fifo_count + inflight < DEPTH, where inflight = valid bits in an RD_LAT-deep tag shift register.
  - On issue: address_b <= base+issued (mod 2^ADDR_W, wraps 0x3FFFF->0x00000); tag bit shifts in 1; issued++.
  - No issue: tag bit shifts in 0; address_b holds its value.
  - issued==length after an issue: go to DRAIN.
- FSM DRAIN: when inflight==0 && fifo empty, go to IDLE; done pulses that same transition cycle.
- Capture: tag shift output==1 means read_data_b is written to the FIFO that edge. Credit accounting guarantees the FIFO is never full on capture (overflow is a design error; assert in sim).
- FIFO: out_valid = !empty and out_data = head, both registered. Simultaneous push and pop allowed at any occupancy; count unchanged.
- Latency: start sampled at edge 0.
  - First address presented after edge 1.
  - First out_valid high after edge 1+RD_LAT+1.
  - With out_ready held high, 1 word/cycle sustained.
- Backpressure: out_ready low stops issue once credits are exhausted. No data loss, no reordering.
- abort (any state): next edge goes to IDLE, FIFO flushed, in-flight tags cleared, out_valid=0, no done pulse. abort with start in the same cycle: abort wins.
- Reset mid-transfer: identical to power-on reset; the transfer is lost.
- Counters are ADDR_W bits. length max 2^ADDR_W-1.

Test Plan:
- base=0x00010, length=4, mem[0x10..0x13]=0xA00001..0xA00004, out_ready=1 -> words emerge in order, first out_valid at cycle 3 (RD_LAT=1), one per cycle; done pulses once after the 4th handshake; busy falls the same edge.
- Same transfer with out_ready toggling 1,0,0,1,... -> same 4 words, no duplicates; fifo_count+inflight never exceeds 4; address_b stalls while credit=0.
- base=0x3FFFE, length=4 -> addresses 0x3FFFE,0x3FFFF,0x00000,0x00001 read in that order.
- length=0 start -> done pulses one cycle later, busy stays 0, out_valid stays 0.
- abort asserted after 2 of 8 words are consumed, out_ready=0 -> out_valid=0 next cycle, busy=0, no done; a new start base=0x100, length=1 then returns only mem[0x100].
- rst driven low asynchronously mid-RUN -> all outputs 0 immediately; after release, IDLE and start is accepted normally.
